// File: rtl/alu_mult_seq.sv
// Iterative shift-and-add 32x32 multiplier (low 32 bits of the product) that borrows the
// execute-stage ALU for every add and shift, one ALU operation per clock.
module alu_mult_seq #(
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        ctrl_start,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result
);

  localparam bit EarlyTerm = (EARLY_TERM != 0);
  localparam logic [4:0] OpAdd = 5'b00000;
  localparam logic [4:0] OpSll = 5'b00100;

  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [31:0] q_shr;
  logic [5:0]  cnt_inc;

  assign q_shr   = q_q >> 1;
  assign cnt_inc = cnt_q + 6'd1;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      p_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      p_q      <= p_d;
      m_q      <= m_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          m_d     = data_operandA;
          q_d     = data_operandB;
          p_d     = '0;
          cnt_d   = '0;
          state_d = (EarlyTerm && (data_operandB == '0)) ? StDone : StAdd;
        end
      end
      StAdd: begin
        if (q_q[0]) begin
          p_d = alu_result;
        end
        state_d = StShift;
      end
      StShift: begin
        m_d   = alu_result;
        q_d   = q_shr;
        cnt_d = cnt_inc;
        if ((cnt_inc == 6'd32) || (EarlyTerm && (q_shr == '0))) begin
          state_d = StDone;
        end else begin
          state_d = StAdd;
        end
      end
      StDone: begin
        result_d = p_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The result is presented straight from P during DONE so it is valid alongside the pulse.
  always_comb begin
    alu_operandA   = '0;
    alu_operandB   = '0;
    alu_opcode     = OpAdd;
    alu_shiftamt   = '0;
    data_resultRDY = 1'b0;
    busy           = (state_q != StIdle);
    data_result    = result_q;
    unique case (state_q)
      StAdd: begin
        alu_operandA = p_q;
        alu_operandB = m_q;
      end
      StShift: begin
        alu_opcode   = OpSll;
        alu_operandA = m_q;
        alu_shiftamt = 5'd1;
      end
      StDone: begin
        data_resultRDY = 1'b1;
        data_result    = p_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: one instance with early termination, one without, each paired with
// a behavioural ALU; checked against a product/latency model and hand-written corner sequences.
module tb_alu_mult_seq;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, b_in;

  logic [31:0] res1, aa1, ab1, ar1;
  logic [4:0]  op1, sh1;
  logic        rdy1, busy1;
  logic [31:0] res0, aa0, ab0, ar0;
  logic [4:0]  op0, sh0;
  logic        rdy0, busy0;

  int total = 0;
  int bad = 0;

  logic [4:0]  op_tr[$];
  logic [31:0] aa_tr[$];
  logic [31:0] ab_tr[$];

  always #5 clock = ~clock;

  assign ar1 = (op1 == 5'b00000) ? aa1 + ab1 : (op1 == 5'b00100) ? aa1 << sh1 : 32'h0;
  assign ar0 = (op0 == 5'b00000) ? aa0 + ab0 : (op0 == 5'b00100) ? aa0 << sh0 : 32'h0;

  alu_mult_seq #(.EARLY_TERM(1)) dut1 (
    .clock(clock), .ctrl_reset_n(rst_n), .ctrl_start(start),
    .data_operandA(a_in), .data_operandB(b_in),
    .data_result(res1), .data_resultRDY(rdy1), .busy(busy1),
    .alu_operandA(aa1), .alu_operandB(ab1), .alu_opcode(op1), .alu_shiftamt(sh1),
    .alu_result(ar1)
  );

  alu_mult_seq #(.EARLY_TERM(0)) dut0 (
    .clock(clock), .ctrl_reset_n(rst_n), .ctrl_start(start),
    .data_operandA(a_in), .data_operandB(b_in),
    .data_result(res0), .data_resultRDY(rdy0), .busy(busy0),
    .alu_operandA(aa0), .alu_operandB(ab0), .alu_opcode(op0), .alu_shiftamt(sh0),
    .alu_result(ar0)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
    end
  endtask

  function automatic int model_cycles(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return 2 * k + 1;
  endfunction

  task automatic wait_rdy1(output int n, output logic [31:0] r);
    n = 0;
    r = '0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (rdy1) begin
        n = i;
        r = res1;
        break;
      end
    end
  endtask

  // Runs one op on both instances; both must be idle on entry.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ex_res, input int ex_cyc);
    int n1 = 0;
    int n0 = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r0 = '0;
    op_tr.delete();
    aa_tr.delete();
    ab_tr.delete();
    @(negedge clock);
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    for (int i = 1; i <= 80 && n0 == 0; i++) begin
      @(negedge clock);
      if (n1 == 0) begin
        op_tr.push_back(op1);
        aa_tr.push_back(aa1);
        ab_tr.push_back(ab1);
      end
      if (rdy1 && n1 == 0) begin
        n1 = i;
        r1 = res1;
      end
      if (rdy0 && n0 == 0) begin
        n0 = i;
        r0 = res0;
      end
    end
    chk({name, " et1 cycle"}, 32'(n1), 32'(ex_cyc));
    chk({name, " et1 result"}, r1, ex_res);
    chk({name, " et0 cycle"}, 32'(n0), 32'd65);
    chk({name, " et0 result"}, r0, ex_res);
    @(negedge clock);
    chk({name, " et0 pulse width"}, {31'b0, rdy0}, 32'd0);
    chk({name, " et0 busy after"}, {31'b0, busy0}, 32'd0);
    chk({name, " et0 result hold"}, res0, ex_res);
    chk({name, " et1 result hold"}, res1, ex_res);
  endtask

  initial begin
    vec_t vecs[6];
    int n;
    int active;
    logic [31:0] r;
    logic [31:0] ra, rb;

    vecs[0] = '{"3x5", 32'd3, 32'd5, 32'd15, 7};
    vecs[1] = '{"m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 7};
    vecs[2] = '{"1234x0", 32'd1234, 32'd0, 32'd0, 1};
    vecs[3] = '{"1xmsb", 32'd1, 32'h8000_0000, 32'h8000_0000, 65};
    vecs[4] = '{"ffffsq", 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 33};
    vecs[5] = '{"2x3", 32'd2, 32'd3, 32'd6, 5};

    rst_n = 1'b0;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    #3;
    chk("reset result", res1, 32'd0);
    chk("reset rdy/busy", {30'b0, rdy1, busy1}, 32'd0);
    chk("reset alu drive", aa1 | ab1 | {27'b0, op1} | {27'b0, sh1}, 32'd0);
    chk("reset et0 result", res0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cyc);
      if (i == 0) begin
        for (int j = 0; j < 6; j++) begin
          chk($sformatf("3x5 opcode trace %0d", j), {27'b0, op_tr[j]},
              (j % 2 == 0) ? 32'd0 : 32'd4);
        end
        chk("3x5 P held over 2nd add", aa_tr[4], 32'd3);
      end
      if (i == 2) begin
        active = 0;
        foreach (op_tr[j]) if (op_tr[j] == 5'b00100 || ab_tr[j] != 0) active++;
        chk("1234x0 no add/shift", 32'(active), 32'd0);
      end
    end

    for (int t = 0; t < 20; t++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", t), ra, rb, ra * rb, model_cycles(rb));
    end

    // Start held high throughout; operands scrambled after accept.
    @(negedge clock);
    a_in = 32'd3;
    b_in = 32'd5;
    start = 1'b1;
    @(posedge clock);
    #1 a_in = $urandom;
    b_in = $urandom | 32'd1;
    wait_rdy1(n, r);
    chk("hold first cycle", 32'(n), 32'd7);
    chk("hold first result", r, 32'd15);
    a_in = 32'd2;
    b_in = 32'd2;
    @(negedge clock);
    chk("hold idle after done", {31'b0, busy1}, 32'd0);
    @(posedge clock);
    #1 start = 1'b0;
    wait_rdy1(n, r);
    chk("hold second cycle", 32'(n), 32'd5);
    chk("hold second result", r, 32'd4);

    // Asynchronous reset in a SHIFT cycle.
    @(negedge clock);
    a_in = 32'h0000_FFFF;
    b_in = 32'h0000_FFFF;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre-reset in shift", {27'b0, op1}, 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst result", res1, 32'd0);
    chk("async rst rdy/busy", {30'b0, rdy1, busy1}, 32'd0);
    chk("async rst alu drive", aa1 | ab1 | {27'b0, op1} | {27'b0, sh1}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    active = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (rdy1 || rdy0 || busy1 || busy0) active++;
    end
    chk("no pulse after reset", 32'(active), 32'd0);
    run_op("after reset 2x3", 32'd2, 32'd3, 32'd6, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
